// File: rtl/mgmt_wb_pkg.sv
// Shared definitions for the management Wishbone port bridge.
// Holds the FSM state encoding, the fixed address width and the default
// error read-data pattern used by mgmt_wb_port_bridge and mgmt_wb_timeout.
package mgmt_wb_pkg;

  localparam int AW    = 32;
  localparam int TMR_W = 16;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mgmt_wb_timeout.sv
// Slave wait-time down-counter: load_i presets TIMEOUT, dec_i counts down to 0.
// Latency: zero_o reflects the registered count (valid the cycle after load/dec).
// Backpressure: none; the counter holds at 0 until reloaded.
// Ports: core_clk/core_rst, load_i, dec_i, zero_o.
module mgmt_wb_timeout
  import mgmt_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic core_clk,
  input  logic core_rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TMR_W'(TIMEOUT);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mgmt_wb_port_bridge.sv
// Management Wishbone master to NPORTS Wishbone slave ports, decoded on adr[31:24].
// Latency: slave strobe 1 cycle after request; master ack/err 1 cycle after slave ack,
//   timeout or decode error. Backpressure: one transaction at a time; master waits on ack/err.
// Ports: m_* master side; s_* shared registered request fields plus per-port
//   cyc/stb/ack/dat; port_ena_i gates ports (mirrored on s_iena_o); err_count_o saturates at 255.
module mgmt_wb_port_bridge
  import mgmt_wb_pkg::*;
#(
  parameter int                  NPORTS    = 2,
  parameter int                  DW        = 32,
  parameter logic [NPORTS*8-1:0] PORT_BASE = {8'h26, 8'h30},
  parameter int unsigned         TIMEOUT   = 255,
  parameter logic [DW-1:0]       ERR_DATA  = DW'(ERR_DATA_DEFAULT)
) (
  input  logic                 core_clk,
  input  logic                 core_rst,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  input  logic                 m_we_i,
  input  logic [DW/8-1:0]      m_sel_i,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [DW-1:0]        m_dat_o,
  input  logic [NPORTS-1:0]    port_ena_i,
  output logic [NPORTS-1:0]    s_iena_o,
  output logic [NPORTS-1:0]    s_cyc_o,
  output logic [NPORTS-1:0]    s_stb_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [NPORTS-1:0]    s_ack_i,
  input  logic [NPORTS*DW-1:0] s_dat_i,
  output logic [7:0]           err_count_o
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    sel_idx_q, sel_idx_d;
  logic             we_q, we_d;
  logic [DW/8-1:0]  sel_q, sel_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    wdat_q, wdat_d;
  logic [DW-1:0]    mdat_q, mdat_d;
  logic             resp_err_q, resp_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic [NPORTS-1:0] req_oh;
  logic             sel_ack;
  logic [DW-1:0]    sel_rdat;
  logic             tmr_load, tmr_dec, tmr_zero;

  // Lowest-index match wins when several bases share the same value.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!hit && (m_adr_i[31:24] == PORT_BASE[i*8 +: 8])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Strobes are live only while waiting on the slave, so leaving REQ drops them.
  always_comb begin
    req_oh = '0;
    for (int i = 0; i < NPORTS; i++) begin
      req_oh[i] = (state_q == ST_REQ) && (sel_idx_q == IW'(i));
    end
  end

  assign sel_ack  = |(s_ack_i & req_oh);
  assign sel_rdat = s_dat_i[sel_idx_q*DW +: DW];

  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    mdat_d     = mdat_q;
    resp_err_d = resp_err_q;
    err_cnt_d  = err_cnt_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          we_d   = m_we_i;
          sel_d  = m_sel_i;
          adr_d  = m_adr_i;
          wdat_d = m_dat_i;
          if (hit && port_ena_i[hit_idx]) begin
            state_d   = ST_REQ;
            sel_idx_d = hit_idx;
            tmr_load  = 1'b1;
          end else begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
            mdat_d     = ERR_DATA;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end
      end
      ST_REQ: begin
        // A master abort beats everything; an ack beats an expiring counter.
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          state_d    = ST_RESP;
          resp_err_d = 1'b0;
          mdat_d     = sel_rdat;
        end else if (tmr_zero) begin
          state_d    = ST_RESP;
          resp_err_d = 1'b1;
          mdat_d     = ERR_DATA;
          err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q    <= ST_IDLE;
      sel_idx_q  <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      mdat_q     <= '0;
      resp_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      mdat_q     <= mdat_d;
      resp_err_q <= resp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  mgmt_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .load_i   (tmr_load),
    .dec_i    (tmr_dec),
    .zero_o   (tmr_zero)
  );

  assign s_iena_o    = port_ena_i;
  assign s_cyc_o     = req_oh;
  assign s_stb_o     = req_oh;
  assign s_we_o      = we_q;
  assign s_sel_o     = sel_q;
  assign s_adr_o     = adr_q;
  assign s_dat_o     = wdat_q;
  assign m_ack_o     = (state_q == ST_RESP) && !resp_err_q;
  assign m_err_o     = (state_q == ST_RESP) &&  resp_err_q;
  assign m_dat_o     = mdat_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_mgmt_wb_port_bridge.sv
// Bench for mgmt_wb_port_bridge: three ports, port0 base 0x26, ports 1 and 2 both 0x30
// (so port1 wins the duplicate), TIMEOUT=4. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_mgmt_wb_port_bridge;

  localparam int NP = 3;
  localparam int DW = 32;

  logic              core_clk = 1'b0;
  logic              core_rst;
  logic              m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]        m_sel_i;
  logic [31:0]       m_adr_i, m_dat_i;
  logic              m_ack_o, m_err_o;
  logic [31:0]       m_dat_o;
  logic [NP-1:0]     port_ena_i, s_iena_o, s_cyc_o, s_stb_o, s_ack_i;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [NP*DW-1:0]  s_dat_i;
  logic [7:0]        err_count_o;

  int errors   = 0;
  int checks   = 0;
  int exp_errs = 0;

  localparam logic [NP*DW-1:0] NOISE = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};

  always #5 core_clk = ~core_clk;

  mgmt_wb_port_bridge #(
    .NPORTS    (NP),
    .DW        (DW),
    .PORT_BASE (24'h30_30_26),
    .TIMEOUT   (4),
    .ERR_DATA  (32'hFFFF_FFFF)
  ) dut (
    .core_clk    (core_clk),
    .core_rst    (core_rst),
    .m_cyc_i     (m_cyc_i),
    .m_stb_i     (m_stb_i),
    .m_we_i      (m_we_i),
    .m_sel_i     (m_sel_i),
    .m_adr_i     (m_adr_i),
    .m_dat_i     (m_dat_i),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .m_dat_o     (m_dat_o),
    .port_ena_i  (port_ena_i),
    .s_iena_o    (s_iena_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_sel_o     (s_sel_o),
    .s_adr_o     (s_adr_o),
    .s_dat_o     (s_dat_o),
    .s_ack_i     (s_ack_i),
    .s_dat_i     (s_dat_i),
    .err_count_o (err_count_o)
  );

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [2:0]  ena;
    int          ack_at;   // strobe cycle (1-based) on which the slave acks; 0 = never
    logic [31:0] rdat;
    logic [2:0]  exp_stb;
    logic        exp_ok;
    int          exp_lat;  // cycles from request to ack/err
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [31:0] adr, input logic we,
                              input logic [31:0] wdat, input logic [2:0] ena, input int ack_at,
                              input logic [31:0] rdat, input logic [2:0] exp_stb,
                              input logic exp_ok, input int exp_lat, input logic [31:0] exp_dat);
    vec_t v;
    v.name = name; v.adr = adr; v.we = we; v.wdat = wdat; v.ena = ena;
    v.ack_at = ack_at; v.rdat = rdat; v.exp_stb = exp_stb; v.exp_ok = exp_ok;
    v.exp_lat = exp_lat; v.exp_dat = exp_dat;
    return v;
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int oh2idx(input logic [2:0] oh);
    int r = 0;
    for (int i = 0; i < NP; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  nstb = 0;
    bit  done = 0;
    int  p    = oh2idx(v.exp_stb);
    logic [31:0] held;
    m_cyc_i    = 1'b1;
    m_stb_i    = 1'b1;
    m_we_i     = v.we;
    m_sel_i    = v.we ? 4'h3 : 4'hF;
    m_adr_i    = v.adr;
    m_dat_i    = v.wdat;
    port_ena_i = v.ena;
    s_ack_i    = '0;
    s_dat_i    = NOISE;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge core_clk);
      if (c == 1) begin
        chk({v.name, "/stb"},  32'(s_stb_o), 32'(v.exp_stb));
        chk({v.name, "/cyc"},  32'(s_cyc_o), 32'(v.exp_stb));
        chk({v.name, "/adr"},  s_adr_o, v.adr);
        chk({v.name, "/we"},   32'(s_we_o), 32'(v.we));
        chk({v.name, "/sel"},  32'(s_sel_o), v.we ? 32'h3 : 32'hF);
        chk({v.name, "/wdat"}, s_dat_o, v.wdat);
        chk({v.name, "/iena"}, 32'(s_iena_o), 32'(v.ena));
      end
      if (m_ack_o || m_err_o) begin
        if (!v.exp_ok) exp_errs++;
        chk({v.name, "/lat"},      32'(c), 32'(v.exp_lat));
        chk({v.name, "/ack"},      32'(m_ack_o), 32'(v.exp_ok));
        chk({v.name, "/err"},      32'(m_err_o), 32'(!v.exp_ok));
        chk({v.name, "/rdat"},     m_dat_o, v.exp_dat);
        chk({v.name, "/stb_drop"}, 32'(s_stb_o), 32'h0);
        chk({v.name, "/stb_cyc"},  32'(nstb), 32'(v.exp_lat - 1));
        chk({v.name, "/errcnt"},   32'(err_count_o), 32'(sat(exp_errs)));
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        done    = 1;
      end else begin
        if (s_stb_o != '0) nstb++;
        // Unselected ports ack every cycle; the bridge must ignore them.
        s_ack_i = (v.ack_at != 0 && nstb == v.ack_at) ? v.exp_stb : ~v.exp_stb;
        s_dat_i = NOISE;
        if (v.exp_stb != '0) s_dat_i[p*DW +: DW] = v.rdat;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s/resp: actual=none required=response within 40 cycles", v.name);
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      s_ack_i = '0;
    end
    held = v.exp_dat;
    @(negedge core_clk);
    chk({v.name, "/idle_ackerr"}, 32'(m_ack_o | m_err_o), 32'h0);
    chk({v.name, "/dat_hold"},    m_dat_o, held);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int npulse;

    vecs.push_back(mk("rd_p1_ack3",   32'h3000_0004, 1'b0, 32'h0,         3'b111, 3, 32'h1234_5678, 3'b010, 1'b1, 4, 32'h1234_5678));
    vecs.push_back(mk("wr_nomatch",   32'h5000_0000, 1'b1, 32'hAAAA_5555, 3'b111, 0, 32'h0,         3'b000, 1'b0, 1, 32'hFFFF_FFFF));
    vecs.push_back(mk("rd_p0_ackzero",32'h2600_0010, 1'b0, 32'h0,         3'b111, 5, 32'hA5A5_0001, 3'b001, 1'b1, 6, 32'hA5A5_0001));
    vecs.push_back(mk("rd_p0_timeout",32'h2600_0020, 1'b0, 32'h0,         3'b111, 0, 32'h0,         3'b001, 1'b0, 6, 32'hFFFF_FFFF));
    vecs.push_back(mk("wr_p0_disabled",32'h2600_0000,1'b1, 32'h1111_2222, 3'b110, 0, 32'h0,         3'b000, 1'b0, 1, 32'hFFFF_FFFF));
    vecs.push_back(mk("wr_p1_ack1",   32'h3000_0008, 1'b1, 32'hCAFE_F00D, 3'b111, 1, 32'h0000_0042, 3'b010, 1'b1, 2, 32'h0000_0042));
    vecs.push_back(mk("rd_p0_ack2",   32'h26FF_FFFC, 1'b0, 32'h0,         3'b011, 2, 32'h8765_4321, 3'b001, 1'b1, 3, 32'h8765_4321));

    core_rst   = 1'b1;
    m_cyc_i    = 1'b0;
    m_stb_i    = 1'b0;
    m_we_i     = 1'b0;
    m_sel_i    = '0;
    m_adr_i    = '0;
    m_dat_i    = '0;
    port_ena_i = 3'b101;
    s_ack_i    = '0;
    s_dat_i    = NOISE;
    repeat (3) @(negedge core_clk);
    chk("rst/stb",    32'(s_stb_o), 32'h0);
    chk("rst/cyc",    32'(s_cyc_o), 32'h0);
    chk("rst/ackerr", 32'(m_ack_o | m_err_o), 32'h0);
    chk("rst/mdat",   m_dat_o, 32'h0);
    chk("rst/errcnt", 32'(err_count_o), 32'h0);
    chk("rst/sadr",   s_adr_o, 32'h0);
    chk("rst/iena",   32'(s_iena_o), 32'h5);
    core_rst   = 1'b0;
    port_ena_i = 3'b111;
    @(negedge core_clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: ok response on port0, master keeps strobing with a new address.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 4'hF;
    m_adr_i = 32'h2600_0040; port_ena_i = 3'b111;
    @(negedge core_clk);
    chk("b2b/stb", 32'(s_stb_o), 32'h1);
    s_ack_i = 3'b001;
    s_dat_i = NOISE; s_dat_i[31:0] = 32'h600D_0001;
    @(negedge core_clk);
    chk("b2b/ack",  32'(m_ack_o), 32'h1);
    chk("b2b/rdat", m_dat_o, 32'h600D_0001);
    s_ack_i = '0;
    m_adr_i = 32'h5000_0000;
    @(negedge core_clk);
    chk("b2b/idle_gap", 32'(m_ack_o | m_err_o), 32'h0);
    @(negedge core_clk);
    chk("b2b/err", 32'(m_err_o), 32'h1);
    exp_errs++;
    chk("b2b/errcnt", 32'(err_count_o), 32'(sat(exp_errs)));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge core_clk);

    // Reset mid-REQ with the selected slave acking in the same cycle.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_sel_i = 4'hF;
    m_adr_i = 32'h3000_0010; m_dat_i = 32'h0F0F_0F0F;
    @(negedge core_clk);
    chk("rstreq/stb", 32'(s_stb_o), 32'h2);
    @(negedge core_clk);
    core_rst = 1'b1;
    s_ack_i  = 3'b010;
    s_dat_i  = NOISE; s_dat_i[63:32] = 32'h7777_7777;
    @(negedge core_clk);
    chk("rstreq/stb0",   32'(s_stb_o), 32'h0);
    chk("rstreq/cyc0",   32'(s_cyc_o), 32'h0);
    chk("rstreq/ackerr", 32'(m_ack_o | m_err_o), 32'h0);
    chk("rstreq/mdat",   m_dat_o, 32'h0);
    chk("rstreq/errcnt", 32'(err_count_o), 32'h0);
    chk("rstreq/sadr",   s_adr_o, 32'h0);
    chk("rstreq/sdat",   s_dat_o, 32'h0);
    chk("rstreq/swe",    32'(s_we_o), 32'h0);
    core_rst = 1'b0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
    exp_errs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge core_clk);
      chk("rstreq/quiet", 32'({m_ack_o, m_err_o, m_dat_o != 32'h0}), 32'h0);
    end

    // Master abort during REQ: strobe drops, no response, count untouched.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
    m_adr_i = 32'h3000_0020;
    @(negedge core_clk);
    chk("abort/stb", 32'(s_stb_o), 32'h2);
    @(negedge core_clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge core_clk);
    chk("abort/stb0", 32'(s_stb_o), 32'h0);
    chk("abort/cyc0", 32'(s_cyc_o), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge core_clk);
      chk("abort/noresp", 32'(m_ack_o | m_err_o), 32'h0);
    end
    chk("abort/errcnt", 32'(err_count_o), 32'(sat(exp_errs)));

    // 300 back-to-back decode errors: counter must stop at 255.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h5000_0000;
    npulse = 0;
    for (int c = 0; c < 1000 && npulse < 300; c++) begin
      @(negedge core_clk);
      if (m_err_o) npulse++;
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    exp_errs += npulse;
    chk("sat/pulses", 32'(npulse), 32'd300);
    chk("sat/count",  32'(err_count_o), 32'd255);
    @(negedge core_clk);
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mgmt_wb_port_bridge.md
MGMT_WB_PORT_BRIDGE -- requirements
Module: mgmt_wb_port_bridge

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of exported Wishbone slave ports (1..8).
REQ-002 SHALL have parameter DW, default 32, data width; AW fixed 32.
REQ-003 SHALL have parameter PORT_BASE, default {8'h26,8'h30}, packed NPORTS x 8-bit adr[31:24] match values, port 0 in LSBs.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum slave wait cycles (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hFFFF_FFFF, read data returned on error.
REQ-006 core_clk  in  1  sole clock, all state on rising edge.
REQ-007 core_rst  in  1  reset, synchronous, active-high.
REQ-008 m_cyc_i, m_stb_i, m_we_i  in  1 each  management-core master request.
REQ-009 m_sel_i  in  DW/8; m_adr_i  in  32; m_dat_i  in  DW  master byte selects, address, write data.
REQ-010 m_ack_o, m_err_o  out  1 each; m_dat_o  out  DW  master response.
REQ-011 port_ena_i  in  NPORTS  per-port enable; also driven out as s_iena_o  out  NPORTS.
REQ-012 s_cyc_o, s_stb_o  out  NPORTS  per-port one-hot request strobes.
REQ-013 s_we_o  out  1; s_sel_o  out  DW/8; s_adr_o  out  32; s_dat_o  out  DW  shared registered request fields.
REQ-014 s_ack_i  in  NPORTS; s_dat_i  in  NPORTS*DW  per-port responses.
REQ-015 err_count_o  out  8  saturating count of error responses.

Function
REQ-016 FSM states IDLE, REQ, RESP, encoded in package enum.
REQ-017 IDLE: on m_cyc_i&m_stb_i, SHALL register m_we/sel/adr/dat into s_* fields and decode adr[31:24] against PORT_BASE.
REQ-018 Match on enabled port: next state REQ, s_cyc_o/s_stb_o bit of that port high from next cycle, timeout counter loaded with TIMEOUT.
REQ-019 No match, or matched port with port_ena_i low: next state RESP with error; no s_stb_o asserted.
REQ-020 Multiple PORT_BASE matches: lowest port index SHALL win.
REQ-021 REQ: s_ack_i of selected port sampled high -> capture its s_dat_i, drop s_cyc/s_stb next cycle, go RESP (ok).
REQ-022 s_ack_i of non-selected ports SHALL be ignored.
REQ-023 REQ: counter decrements each cycle; at 0 without ack -> drop s_cyc/s_stb, go RESP (error).
REQ-024 Ack and counter-zero in same cycle: ack SHALL win.
REQ-025 REQ: m_cyc_i low -> drop s_cyc/s_stb next cycle, return IDLE, no m_ack_o/m_err_o, err_count_o unchanged.
REQ-026 RESP lasts exactly 1 cycle: m_ack_o=1 (ok) or m_err_o=1 (error), never both; m_dat_o = captured data or ERR_DATA; then IDLE.
REQ-027 m_ack_o, m_err_o SHALL be 0 outside RESP; m_dat_o holds last value.
REQ-028 Latency: request seen in IDLE at cycle t -> s_stb_o at t+1; slave ack at cycle k -> m_ack_o at k+1; decode error -> m_err_o at t+1.
REQ-029 Back-to-back: request present in IDLE immediately after RESP SHALL be accepted without idle gap.
REQ-030 err_count_o increments on each m_err_o pulse, saturates at 255, never wraps.

Reset
REQ-031 core_rst high at any edge, including mid-transaction: state IDLE, all s_cyc/s_stb/m_ack/m_err 0, s_* fields, m_dat_o, counter, err_count_o 0 on next edge.
REQ-032 Slave ack arriving in the cycle of reset SHALL be discarded.

Structure
REQ-033 Package mgmt_wb_pkg SHALL hold state enum, default ERR_DATA, AW constant.
REQ-034 Timeout down-counter SHALL be sub-module mgmt_wb_timeout (load, decrement, zero flag).

Verification
REQ-035 Read adr 0x3000_0004, port1 acks after 3 cycles with 0x1234_5678 -> s_stb_o=2'b10 at t+1, m_ack_o one cycle, m_dat_o=0x1234_5678.
REQ-036 Write adr 0x5000_0000 (no match) -> m_err_o at t+1, no s_stb_o, err_count_o=1.
REQ-037 TIMEOUT=4, port0 never acks -> s_stb_o drops, m_err_o after 5 cycles, m_dat_o=0xFFFF_FFFF.
REQ-038 Ack on cycle counter hits 0 -> m_ack_o, not m_err_o; port_ena_i[0]=0 access -> immediate m_err_o.
REQ-039 core_rst pulsed during REQ, then m_cyc_i drop during REQ -> all outputs 0, no response pulse.
REQ-040 300 error transactions -> err_count_o=255 held.
